// File: rtl/mul_core_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_core_if
// Description : Bus-slave to multiplier-core operand/result interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_core_if #(
    parameter int ADDR_W = 4
);
    logic              opstart;
    logic              opclear;
    logic              cand_we;
    logic              lier_we;
    logic [31:0]       multiplicand;
    logic [31:0]       multiplier;
    logic [ADDR_W-1:0] rAddr;
    logic [31:0]       result;
    logic              opdone;

    modport master (
        output opstart, opclear, cand_we, lier_we, multiplicand, multiplier, rAddr,
        input  result, opdone
    );

    modport slave (
        input  opstart, opclear, cand_we, lier_we, multiplicand, multiplier, rAddr,
        output result, opdone
    );
endinterface
`default_nettype wire

// File: rtl/mul_core.sv
`default_nettype none
// ============================================================================
// Module      : mul_core
// Description : Signed 32x32 Booth multiplier with operand FIFOs and a result
//               buffer. Define MUL_RADIX4_EN for radix-4 Booth (16 steps).
// Revision    : 1.0 - initial release
// ============================================================================
module mul_core #(
    parameter int FIFO_DEPTH = 8,
    parameter int RBUF_WORDS = 16
) (
    input  wire logic  clk,
    input  wire logic  reset_n,
    mul_core_if.slave  bus
);
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_WADDR_W = $clog2(RBUF_WORDS);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
`ifdef MUL_RADIX4_EN
    localparam logic [4:0] c_LAST_STEP = 5'd15;
`else
    localparam logic [4:0] c_LAST_STEP = 5'd31;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [31:0]          r_cand_mem [FIFO_DEPTH];
    logic [31:0]          r_lier_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_cand_wp, r_cand_rp, r_lier_wp, r_lier_rp;
    logic [c_CNT_W-1:0]   r_cand_cnt, r_lier_cnt;
    logic [31:0]          r_rbuf [RBUF_WORDS];
    logic [c_WADDR_W-1:0] r_wptr;
    logic [64:0]          r_acc;
    logic [31:0]          r_a;
    logic [4:0]           r_step;

    logic                 w_cand_push, w_lier_push, w_pop, w_pairs_avail;
    logic [c_WADDR_W-1:0] w_wptr_hi, w_wptr_inc;
    logic [64:0]          w_acc_step;

    assign w_cand_push   = bus.cand_we && (r_cand_cnt != c_FULL);
    assign w_lier_push   = bus.lier_we && (r_lier_cnt != c_FULL);
    assign w_pop         = (r_state == S_LOAD);
    assign w_pairs_avail = (r_cand_cnt != '0) && (r_lier_cnt != '0);
    assign w_wptr_hi     = r_wptr + c_WADDR_W'(1);
    assign w_wptr_inc    = r_wptr + c_WADDR_W'(2);

    // One Booth step: add the recoded multiple of A into the sign-extended
    // upper half, then shift the whole accumulator arithmetically.
`ifdef MUL_RADIX4_EN
    logic [33:0] w_upper, w_a1, w_a2, w_sum;
    always_comb begin
        w_upper = {{2{r_acc[64]}}, r_acc[64:33]};
        w_a1    = {{2{r_a[31]}}, r_a};
        w_a2    = {r_a[31], r_a, 1'b0};
        w_sum   = w_upper;
        case (r_acc[2:0])
            3'b001, 3'b010: w_sum = w_upper + w_a1;
            3'b011:         w_sum = w_upper + w_a2;
            3'b100:         w_sum = w_upper - w_a2;
            3'b101, 3'b110: w_sum = w_upper - w_a1;
            default:        w_sum = w_upper;
        endcase
        w_acc_step = {w_sum, r_acc[32:2]};
    end
`else
    logic [32:0] w_upper, w_a1, w_sum;
    always_comb begin
        w_upper = {r_acc[64], r_acc[64:33]};
        w_a1    = {r_a[31], r_a};
        w_sum   = w_upper;
        case (r_acc[1:0])
            2'b01:   w_sum = w_upper + w_a1;
            2'b10:   w_sum = w_upper - w_a1;
            default: w_sum = w_upper;
        endcase
        w_acc_step = {w_sum, r_acc[32:1]};
    end
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.opstart) w_state_next = w_pairs_avail ? S_LOAD : S_DONE;
            S_LOAD:  w_state_next = S_EXEC;
            S_EXEC:  if (r_step == c_LAST_STEP) w_state_next = S_WRITE;
            S_WRITE: w_state_next = (w_pairs_avail && (w_wptr_inc != '0)) ? S_LOAD : S_DONE;
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else if (bus.opclear)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // FIFO storage needs no reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (w_cand_push && !bus.opclear) r_cand_mem[r_cand_wp] <= bus.multiplicand;
        if (w_lier_push && !bus.opclear) r_lier_mem[r_lier_wp] <= bus.multiplier;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cand_wp  <= '0;
            r_cand_rp  <= '0;
            r_lier_wp  <= '0;
            r_lier_rp  <= '0;
            r_cand_cnt <= '0;
            r_lier_cnt <= '0;
            r_wptr     <= '0;
            r_acc      <= '0;
            r_a        <= '0;
            r_step     <= '0;
            for (int i = 0; i < RBUF_WORDS; i++) r_rbuf[i] <= '0;
        end else if (bus.opclear) begin
            r_cand_wp  <= '0;
            r_cand_rp  <= '0;
            r_lier_wp  <= '0;
            r_lier_rp  <= '0;
            r_cand_cnt <= '0;
            r_lier_cnt <= '0;
            r_wptr     <= '0;
            for (int i = 0; i < RBUF_WORDS; i++) r_rbuf[i] <= '0;
        end else begin
            if (w_cand_push) r_cand_wp <= r_cand_wp + c_PTR_W'(1);
            if (w_lier_push) r_lier_wp <= r_lier_wp + c_PTR_W'(1);
            if (w_pop) begin
                r_cand_rp <= r_cand_rp + c_PTR_W'(1);
                r_lier_rp <= r_lier_rp + c_PTR_W'(1);
            end
            case ({w_cand_push, w_pop})
                2'b10:   r_cand_cnt <= r_cand_cnt + c_CNT_W'(1);
                2'b01:   r_cand_cnt <= r_cand_cnt - c_CNT_W'(1);
                default: r_cand_cnt <= r_cand_cnt;
            endcase
            case ({w_lier_push, w_pop})
                2'b10:   r_lier_cnt <= r_lier_cnt + c_CNT_W'(1);
                2'b01:   r_lier_cnt <= r_lier_cnt - c_CNT_W'(1);
                default: r_lier_cnt <= r_lier_cnt;
            endcase

            case (r_state)
                S_LOAD: begin
                    r_a    <= r_cand_mem[r_cand_rp];
                    r_acc  <= {32'b0, r_lier_mem[r_lier_rp], 1'b0};
                    r_step <= '0;
                end
                S_EXEC: begin
                    r_acc  <= w_acc_step;
                    r_step <= r_step + 5'd1;
                end
                S_WRITE: begin
                    r_rbuf[r_wptr]    <= r_acc[32:1];
                    r_rbuf[w_wptr_hi] <= r_acc[64:33];
                    r_wptr            <= w_wptr_inc;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_rbuf[bus.rAddr];
    assign bus.opdone = (r_state == S_DONE);
endmodule
`default_nettype wire

// File: doc/mul_core.md
# mul_core

Two's-complement 32×32 multiplier engine. Sits directly downstream of the multiplier bus slave, which supplies operands, `opstart`, and `opclear`. Operands are queued in two 8-entry FIFOs. Each operand pair runs through a sequential shift-add datapath, and each 64-bit product goes into a 16-word result buffer. The slave reads the buffer back word by word through `rAddr`/`result`.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: entries per operand FIFO (power of two).
- `RBUF_WORDS`, 16: 32-bit result buffer words; must equal 2×`FIFO_DEPTH`.

Ports:
- `clk` in 1: single clock; rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `opstart` in 1: start processing queued pairs; sampled in IDLE only.
- `opclear` in 1: synchronous clear of FIFOs, buffer, and FSM; highest priority.
- `cand_we` in 1: push `multiplicand` into the candidate FIFO.
- `lier_we` in 1: push `multiplier` into the multiplier FIFO.
- `multiplicand` in 32: signed operand A.
- `multiplier` in 32: signed operand B.
- `rAddr` in 4: result buffer read index.
- `result` out 32: combinational `rbuf[rAddr]`.
- `opdone` out 1: high while the FSM is in DONE.

## Operation
- **Operand FIFOs**
  - Each FIFO has 3-bit read and write pointers plus a 4-bit count.
  - Push on `*_we` when count < 8. A push when full is dropped, with no state change.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pushes are accepted in every state.
- **Pairs available** = min(candidate count, multiplier count).
- **FSM states:** IDLE, LOAD, EXEC, WRITE, DONE.
  - IDLE: on `opstart`, go to LOAD if pairs ≥ 1, otherwise go to DONE (zero-pair run).
  - LOAD: pop one entry from each FIFO. Initialise the accumulator with {32'b0, B, 1'b0} and the step counter. Go to EXEC.
  - EXEC: one radix-2 Booth step per cycle on bit pair {B[i], B[i-1]}:
    - 01 → +A
    - 10 → −A
    - Add into the upper 33 bits, then arithmetic right shift.
    - After 32 steps, go to WRITE.
  - WRITE: write the product low word to `rbuf[wptr]` and the high word to `rbuf[wptr+1]`; `wptr += 2`. If pairs ≥ 1 and `wptr` ≠ 0 after the increment (buffer not full), go to LOAD. Otherwise go to DONE.
  - DONE: `opdone` = 1. Hold until `opclear`.
- **Product:** exact signed 64-bit value, with no truncation. Product k (0-based) occupies words 2k (low) and 2k+1 (high).
- **Buffer wrap:** `wptr` is 4 bits. After 8 products the run stops in DONE even if FIFO pairs remain; the leftover entries stay queued.
- **Unmatched entries:** extra entries in the longer FIFO stay queued.
- **`opclear`** (any state, overrides `opstart` and the `*_we` inputs in the same cycle):
  - FIFO pointers, counts, and `wptr` go to 0.
  - All `rbuf` words go to 0.
  - FSM goes to IDLE on the next edge, so `opdone` falls one cycle after `opclear` is sampled.
- **`opstart` outside IDLE** is ignored.
- **Reset (`reset_n` low, asynchronous):** same state as after `opclear`. `result` = 0 and `opdone` = 0. Reset mid-EXEC abandons the product; nothing is written.

## Timing
- `opstart` is sampled high in IDLE at edge N.
- Radix-2 pair latency: 34 cycles (LOAD 1 + EXEC 32 + WRITE 1).
- With k pairs, `opdone` rises after edge N + 34k.
- With zero pairs, `opdone` rises after edge N.
- Buffer words are visible on `result` the cycle after their WRITE edge.
- `result` has zero-latency combinational read. The slave registers it.
- FIFO push takes effect at the edge where `*_we` is high. An entry pushed at that same edge is eligible for the next LOAD.

## Configuration
- `MUL_RADIX4_EN` defined:
  - EXEC uses radix-4 Booth on bit triplets {B[2i+1], B[2i], B[2i-1]}, with recoded digits in {0, ±A, ±2A}, a 34-bit add, and an arithmetic shift by 2.
  - 16 EXEC cycles; pair latency 18 and k-pair latency 18k.
- Undefined: radix-2 Booth with 32 EXEC cycles, as described above.
- Results are bit-identical in both configurations.

## Test plan
- Push A=0xFFFFFFFF, B=0x00000001; pulse `opstart` → after 34 cycles (18 with `MUL_RADIX4_EN`) `opdone`=1; rAddr 0 and 1 both read 0xFFFFFFFF.
- A=0x80000000, B=0x80000000 → word0=0x00000000, word1=0x40000000.
- 3 pairs (7×6, −3×5, 0x7FFFFFFF×0x7FFFFFFF) → words 0..5 = 0x0000002A, 0x00000000, 0xFFFFFFF1, 0xFFFFFFFF, 0x00000001, 0x3FFFFFFF; `opdone` rises after 102 cycles.
- 9 pushes each to a full FIFO → 9th push dropped. Then `opstart` → 8 products, `opdone`=1, word 15 written, both counts 0.
- `opstart` with candidate FIFO empty and multiplier FIFO holding 2 → `opdone` on the next cycle; multiplier count stays 2.
- `opclear` mid-EXEC → next cycle IDLE, all `rbuf` words 0, counts 0. Also assert `reset_n` low mid-EXEC → `opdone`=0 and `result`=0 immediately.
